cskipa_seq_ctrl: RTL and testbench

- Multi-cycle sequencer that computes a wide addition (SLICE_W*NUM_SLICES bits) by time-multiplexing one SLICE_W-bit carry-skip adder slice.
- Processes one slice per cycle, least-significant first, with a registered inter-slice carry.
- Operand intake and result delivery use valid/ready handshakes.
- Sits between the operand source and the consumer in the adder-classification datapath, where width must scale without replicating skip hardware.

---
 rtl/cskipa_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_cskipa_seq_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cskipa_seq_ctrl.sv
// cskipa_seq_ctrl: wide unsigned adder built by time-multiplexing one
// SLICE_W-bit carry-skip slice over NUM_SLICES cycles, LSB slice first.
// Operands come in and the result goes out over valid/ready handshakes.
// Optional feature: define CSKIP_SEQ_OVF_EN to add the signed-overflow
// output ovf.
module cskipa_seq_ctrl #(
    parameter int SLICE_W    = 12,
    parameter int NUM_SLICES = 4,
    localparam int TOT_W     = SLICE_W * NUM_SLICES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TOT_W-1:0] i_add_term1,
    input  logic [TOT_W-1:0] i_add_term2,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TOT_W-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef CSKIP_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NBLK  = SLICE_W / 4;
    localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q;
    logic [TOT_W-1:0]   a_q, b_q, sum_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q, cout_q;
    logic               in_ready_q, out_valid_q, busy_q;
`ifdef CSKIP_SEQ_OVF_EN
    logic               ovf_q;
`endif

    // Slice datapath signals (combinational)
    logic [SLICE_W-1:0] slice_a, slice_b, prop, gen, sum_d;
    logic               carry_d, blk_cin, rip_c, blk_p;

    // Carry-skip slice: ripple inside each 4-bit block, skip mux across it.
    always_comb begin
        // NOTE: every variable gets a default before any conditional or loop
        // update, so no path leaves a value held and no latch is inferred.
        slice_a = a_q[int'(idx_q) * SLICE_W +: SLICE_W];
        slice_b = b_q[int'(idx_q) * SLICE_W +: SLICE_W];
        prop    = slice_a ^ slice_b;
        gen     = slice_a & slice_b;
        sum_d   = '0;
        carry_d = carry_q;
        blk_cin = 1'b0;
        rip_c   = 1'b0;
        blk_p   = 1'b0;
        // NOTE: blocking assignments here are deliberate: each loop step must
        // see the carry produced by the step before it within the same cycle.
        for (int blk = 0; blk < NBLK; blk++) begin
            blk_cin = carry_d;
            rip_c   = carry_d;
            blk_p   = &prop[blk*4 +: 4];
            for (int j = 0; j < 4; j++) begin
                sum_d[blk*4 + j] = prop[blk*4 + j] ^ rip_c;
                rip_c            = gen[blk*4 + j] | (prop[blk*4 + j] & rip_c);
            end
            carry_d = blk_p ? blk_cin : rip_c;
        end
    end

    // Operand shadow registers, loaded on the input handshake.
    always_ff @(posedge clk) begin
        // NOTE: these are not reset: they are only read in RUN, which is
        // always entered through the load below, so a reset value is unused.
        if (state_q == IDLE && in_valid && in_ready_q) begin
            a_q <= i_add_term1;
            b_q <= i_add_term2;
        end
    end

    // Control FSM with registered handshake/status outputs and result regs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef CSKIP_SEQ_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        carry_q    <= cin;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    sum_q[int'(idx_q) * SLICE_W +: SLICE_W] <= sum_d;
                    carry_q <= carry_d;
                    if (idx_q == LAST_IDX) begin
                        cout_q      <= carry_d;
                        idx_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
`ifdef CSKIP_SEQ_OVF_EN
                        // Carry into the MSB recovered from its sum bit.
                        ovf_q <= (sum_d[SLICE_W-1] ^ prop[SLICE_W-1]) ^ carry_d;
`endif
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef CSKIP_SEQ_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cskipa_seq_ctrl.sv
// Directed and randomized bench for cskipa_seq_ctrl (default 12x4 = 48 bits).
// The ovf checks are compiled in when CSKIP_SEQ_OVF_EN is defined.
module tb_cskipa_seq_ctrl;

    localparam int NS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [47:0] i_add_term1 = '0;
    logic [47:0] i_add_term2 = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [47:0] sum;
    logic        cout;
    logic        busy;
`ifdef CSKIP_SEQ_OVF_EN
    logic        ovf;
`endif

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int cyc     = 0;
    int last_hs = -1;
    int last_acc = -1;

    cskipa_seq_ctrl #(.SLICE_W(12), .NUM_SLICES(NS)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .i_add_term1 (i_add_term1),
        .i_add_term2 (i_add_term2),
        .cin         (cin),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sum         (sum),
        .cout        (cout),
        .busy        (busy)
`ifdef CSKIP_SEQ_OVF_EN
        ,
        .ovf         (ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] rnd48();
        return 48'({$urandom(), $urandom()});
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
`ifdef CSKIP_SEQ_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        tick();
        rst = 1'b0;
        last_hs = -1;
    endtask

    // One full transaction: accept, run, optional stall, result handshake.
    task automatic do_op(input logic [47:0] a, input logic [47:0] b, input logic c,
                         input logic [47:0] es, input logic ec,
                         input int stall, input bit hold,
                         input logic [47:0] na, input logic [47:0] nb, input logic nc);
        int acc;
        in_valid    = 1'b1;
        i_add_term1 = a;
        i_add_term2 = b;
        cin         = c;
        out_ready   = 1'b0;
        check("idle_in_ready", in_ready, 1);
        tick();
        acc = cyc;
        if (last_hs >= 0) begin
            check("accept_after_idle", acc - last_hs, 1);
            check("issue_interval_ge6", (acc - last_acc) >= 6, 1);
        end
        last_acc = acc;
        in_valid    = 1'b0;
        i_add_term1 = rnd48();
        i_add_term2 = rnd48();
        cin         = 1'($urandom_range(0, 1));
        for (int k = 0; k < NS - 1; k++) begin
            tick();
            check("run_out_valid_low", out_valid, 0);
            check("run_in_ready_low", in_ready, 0);
            check("run_busy", busy, 1);
        end
        tick();
        check("latency_out_valid", out_valid, 1);
        check("sum", sum, es);
        check("cout", cout, ec);
`ifdef CSKIP_SEQ_OVF_EN
        check("ovf", ovf, (a[47] == b[47]) && (es[47] != a[47]));
`endif
        for (int k = 0; k < stall; k++) begin
            if (hold) begin
                in_valid    = 1'b1;
                i_add_term1 = na;
                i_add_term2 = nb;
                cin         = nc;
            end
            tick();
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            check("stall_sum", sum, es);
            check("stall_cout", cout, ec);
        end
        out_ready = 1'b1;
        tick();
        last_hs   = cyc;
        out_ready = 1'b0;
        check("hs_out_valid_drop", out_valid, 0);
        check("hs_in_ready", in_ready, 1);
        check("hs_busy", busy, 0);
    endtask

    initial begin
        logic [47:0] ca, cb, na, nb, es;
        logic        cc, nc, ec;
        int          stall;
        bit          hold;

        // Reset from power-up.
        do_reset();

        // Carry rippling across slice boundaries.
        do_op(48'h0000_0000_0FFF, 48'h0000_0000_0001, 1'b0, 48'h0000_0000_1000, 1'b0, 0, 0, '0, '0, 1'b0);
        do_op(48'hFFFF_FFFF_FFFF, 48'h0000_0000_0000, 1'b1, 48'h0000_0000_0000, 1'b1, 0, 0, '0, '0, 1'b0);

        // All-propagate operands: every skip mux is taken.
        do_op(48'h5555_5555_5555, 48'hAAAA_AAAA_AAAA, 1'b1, 48'h0000_0000_0000, 1'b1, 0, 0, '0, '0, 1'b0);
        do_op(48'h5555_5555_5555, 48'hAAAA_AAAA_AAAA, 1'b0, 48'hFFFF_FFFF_FFFF, 1'b0, 0, 0, '0, '0, 1'b0);

        // Backpressure: 5 stall cycles with the next request held high.
        do_op(48'h1234_5678_9ABC, 48'h1111_1111_1111, 1'b0, 48'h2345_6789_ABCD, 1'b0, 5, 1,
              48'hFFFF_0000_FFFF, 48'h0001_0000_0001, 1'b0);
        do_op(48'hFFFF_0000_FFFF, 48'h0001_0000_0001, 1'b0, 48'h0000_0001_0000, 1'b1, 0, 0, '0, '0, 1'b0);

        // Signed-overflow vectors (sum/cout checked in every build).
        do_op(48'h7FFF_FFFF_FFFF, 48'h0000_0000_0001, 1'b0, 48'h8000_0000_0000, 1'b0, 0, 0, '0, '0, 1'b0);
        do_op(48'h8000_0000_0000, 48'h8000_0000_0000, 1'b0, 48'h0000_0000_0000, 1'b1, 0, 0, '0, '0, 1'b0);
        do_op(48'h0000_0000_0005, 48'h0000_0000_0003, 1'b0, 48'h0000_0000_0008, 1'b0, 0, 0, '0, '0, 1'b0);

        // Reset mid-RUN after two slices: no result may appear.
        in_valid    = 1'b1;
        i_add_term1 = 48'hFFFF_FFFF_FFFF;
        i_add_term2 = 48'h0000_0000_0001;
        cin         = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("midrun_busy", busy, 1);
        do_reset();
        for (int k = 0; k < 6; k++) begin
            tick();
            check("post_rst_no_out_valid", out_valid, 0);
            check("post_rst_in_ready", in_ready, 1);
        end

        // Reset while holding a result in DONE.
        in_valid    = 1'b1;
        i_add_term1 = 48'h0000_0000_0001;
        i_add_term2 = 48'h0000_0000_0001;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < NS; k++) tick();
        check("done_before_rst", out_valid, 1);
        do_reset();

        // Back-to-back random operations with random stalls.
        ca = rnd48();
        cb = rnd48();
        cc = 1'($urandom_range(0, 1));
        for (int i = 0; i < 1000; i++) begin
            na    = rnd48();
            nb    = rnd48();
            nc    = 1'($urandom_range(0, 1));
            {ec, es} = {1'b0, ca} + {1'b0, cb} + 49'(cc);
            stall = int'($urandom_range(0, 3));
            hold  = 1'($urandom_range(0, 1));
            do_op(ca, cb, cc, es, ec, stall, hold, na, nb, nc);
            ca = na;
            cb = nb;
            cc = nc;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
